mam_wb_arbiter_nport: RTL and testbench

- N-master Wishbone arbiter in front of one memory slave port, with a dedicated MAM debug master at highest priority.
- Round-robin fairness among the NUM_MASTERS CPU-side masters. Grant is held for the whole cycle (cyc), so bursts are never split.
- Sits between the tile CPU/DMA masters, the MAM, and the tile memory. Status outputs expose the current grant for debug/trace.

---
 rtl/mam_wb_arbiter_nport.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_mam_wb_arbiter_nport.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mam_wb_arbiter_nport.sv
// mam_wb_arbiter_nport
//   Wishbone arbiter placing NUM_MASTERS CPU-side masters and one MAM debug
//   master in front of a single memory slave port.
//   - MAM has absolute priority whenever the arbiter is idle.
//   - CPU masters share the port round-robin, starting after the last winner.
//   - A grant lasts for the whole cyc, so bursts are never split.
//   - Grants are registered, so the slave sees cyc one cycle after a master raises it.
//
// Handshake: a master transfer is offered by cyc&stb and completes in the
//   cycle the slave returns ack (or err/rty). The arbiter adds no buffering.
//   Request signals pass combinationally from the granted master to the
//   slave. Responses pass combinationally from the slave back to that same
//   master only.
//
// Ports:
//   wb_in_clk_i, wb_in_rst_i      clock, asynchronous active-high reset
//   wb_in_*                       CPU masters; master k uses slice [k*W +: W]
//   wb_mam_*                      MAM debug master
//   wb_out_*                      memory slave port
//   grant_mam_o, grant_o          current grant (grant_o is one-hot or zero)
//   state_o                       FSM state (0 idle, 1 MAM, 2 CPU)
//   timeout_o                     sticky watchdog flag (only with the macro)
//
// Optional feature: define MAM_WB_ARB_TIMEOUT_EN for the stall watchdog.
//   When a granted transfer waits TIMEOUT cycles, the arbiter returns err to
//   the granted master, masks cyc/stb towards the slave for that cycle, and
//   goes back to idle.
module mam_wb_arbiter_nport #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255,
  localparam int SW = DW / 8,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      wb_in_clk_i,
  input  logic                      wb_in_rst_i,
  input  logic [NUM_MASTERS*AW-1:0] wb_in_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] wb_in_dat_i,
  input  logic [NUM_MASTERS*SW-1:0] wb_in_sel_i,
  input  logic [NUM_MASTERS*3-1:0]  wb_in_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wb_in_bte_i,
  input  logic [NUM_MASTERS-1:0]    wb_in_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wb_in_stb_i,
  input  logic [NUM_MASTERS-1:0]    wb_in_we_i,
  output logic [NUM_MASTERS-1:0]    wb_in_ack_o,
  output logic [NUM_MASTERS-1:0]    wb_in_err_o,
  output logic [NUM_MASTERS-1:0]    wb_in_rty_o,
  output logic [NUM_MASTERS*DW-1:0] wb_in_dat_o,
  input  logic [AW-1:0]             wb_mam_adr_o,
  input  logic [DW-1:0]             wb_mam_dat_o,
  input  logic [SW-1:0]             wb_mam_sel_o,
  input  logic [2:0]                wb_mam_cti_o,
  input  logic [1:0]                wb_mam_bte_o,
  input  logic                      wb_mam_cyc_o,
  input  logic                      wb_mam_stb_o,
  input  logic                      wb_mam_we_o,
  output logic                      wb_mam_ack_i,
  output logic                      wb_mam_err_i,
  output logic                      wb_mam_rty_i,
  output logic [DW-1:0]             wb_mam_dat_i,
  output logic [AW-1:0]             wb_out_adr_i,
  output logic [DW-1:0]             wb_out_dat_i,
  output logic [SW-1:0]             wb_out_sel_i,
  output logic [2:0]                wb_out_cti_i,
  output logic [1:0]                wb_out_bte_i,
  output logic                      wb_out_cyc_i,
  output logic                      wb_out_stb_i,
  output logic                      wb_out_we_i,
  input  logic                      wb_out_ack_o,
  input  logic                      wb_out_err_o,
  input  logic                      wb_out_rty_o,
  input  logic [DW-1:0]             wb_out_dat_o,
  output logic                      grant_mam_o,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic [1:0]                state_o
`ifdef MAM_WB_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_o
`endif
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_MAM = 2'd1;
  localparam logic [1:0] ST_GRANT_CPU = 2'd2;

  // Elaboration-time parameter sanity.
  if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
    $error("mam_wb_arbiter_nport: DW must be 8, 16 or 32");
  end
  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_nm
    $error("mam_wb_arbiter_nport: NUM_MASTERS must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_to
    $error("mam_wb_arbiter_nport: TIMEOUT must be 1..65535");
  end

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] grant_idx;   // CPU master currently (or last) granted
  logic [IW-1:0] last_grant;  // round-robin pointer
  logic [IW-1:0] winner;
  logic          win_found;
  logic          timeout_hit;

  // Request fields of the granted CPU master.
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;
  logic [SW-1:0] sel_sel;
  logic [2:0]    sel_cti;
  logic [1:0]    sel_bte;
  logic          sel_cyc, sel_stb, sel_we;
  logic          pre_stb;     // forwarded stb before watchdog masking

  // Round-robin search starting one past the last CPU winner.
  always_comb begin
    win_found = 1'b0;
    winner    = last_grant;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      int idx;
      idx = (int'(last_grant) + 1 + i) % NUM_MASTERS;
      if (!win_found && wb_in_cyc_i[idx]) begin
        win_found = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    sel_cti = '0;
    sel_bte = '0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_adr = wb_in_adr_i[k*AW +: AW];
        sel_dat = wb_in_dat_i[k*DW +: DW];
        sel_sel = wb_in_sel_i[k*SW +: SW];
        sel_cti = wb_in_cti_i[k*3 +: 3];
        sel_bte = wb_in_bte_i[k*2 +: 2];
        sel_cyc = wb_in_cyc_i[k];
        sel_stb = wb_in_stb_i[k];
        sel_we  = wb_in_we_i[k];
      end
    end
  end

  // Forward path. Idle drives all zeros, so the slave never sees a cycle
  // without an owner.
  always_comb begin
    wb_out_adr_i = '0;
    wb_out_dat_i = '0;
    wb_out_sel_i = '0;
    wb_out_cti_i = '0;
    wb_out_bte_i = '0;
    wb_out_cyc_i = 1'b0;
    pre_stb      = 1'b0;
    wb_out_we_i  = 1'b0;
    case (state)
      ST_GRANT_MAM: begin
        wb_out_adr_i = wb_mam_adr_o;
        wb_out_dat_i = wb_mam_dat_o;
        wb_out_sel_i = wb_mam_sel_o;
        wb_out_cti_i = wb_mam_cti_o;
        wb_out_bte_i = wb_mam_bte_o;
        wb_out_cyc_i = wb_mam_cyc_o;
        pre_stb      = wb_mam_stb_o;
        wb_out_we_i  = wb_mam_we_o;
      end
      ST_GRANT_CPU: begin
        wb_out_adr_i = sel_adr;
        wb_out_dat_i = sel_dat;
        wb_out_sel_i = sel_sel;
        wb_out_cti_i = sel_cti;
        wb_out_bte_i = sel_bte;
        wb_out_cyc_i = sel_cyc;
        pre_stb      = sel_stb;
        wb_out_we_i  = sel_we;
      end
      default: ;
    endcase
    // The slave sees the aborted transfer as a dropped cycle.
    if (timeout_hit) begin
      wb_out_cyc_i = 1'b0;
    end
  end

  assign wb_out_stb_i = pre_stb & ~timeout_hit;

  // Return path: only the owner sees responses. Responses that arrive while
  // idle go nowhere.
  always_comb begin
    wb_in_ack_o  = '0;
    wb_in_err_o  = '0;
    wb_in_rty_o  = '0;
    wb_in_dat_o  = '0;
    wb_mam_ack_i = 1'b0;
    wb_mam_err_i = 1'b0;
    wb_mam_rty_i = 1'b0;
    wb_mam_dat_i = '0;
    if (state == ST_GRANT_MAM) begin
      wb_mam_ack_i = wb_out_ack_o;
      wb_mam_err_i = wb_out_err_o | timeout_hit;
      wb_mam_rty_i = wb_out_rty_o;
      wb_mam_dat_i = wb_out_dat_o;
    end else if (state == ST_GRANT_CPU) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_idx == IW'(k)) begin
          wb_in_ack_o[k]          = wb_out_ack_o;
          wb_in_err_o[k]          = wb_out_err_o | timeout_hit;
          wb_in_rty_o[k]          = wb_out_rty_o;
          wb_in_dat_o[k*DW +: DW] = wb_out_dat_o;
        end
      end
    end
  end

  // Every grant returns through idle. This gives the MAM a chance to win
  // between two CPU cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wb_mam_cyc_o) begin
          state_nxt = ST_GRANT_MAM;
        end else if (win_found) begin
          state_nxt = ST_GRANT_CPU;
        end
      end
      ST_GRANT_MAM: if (!wb_mam_cyc_o) state_nxt = ST_IDLE;
      ST_GRANT_CPU: if (!sel_cyc) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge wb_in_clk_i or posedge wb_in_rst_i) begin
    if (wb_in_rst_i) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      // The MAM grant leaves the CPU round-robin pointer untouched.
      if (state == ST_IDLE && !wb_mam_cyc_o && win_found) begin
        grant_idx  <= winner;
        last_grant <= winner;
      end
    end
  end

  assign grant_mam_o = (state == ST_GRANT_MAM);
  assign state_o     = state;

  always_comb begin
    grant_o = '0;
    if (state == ST_GRANT_CPU) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_idx == IW'(k)) grant_o[k] = 1'b1;
      end
    end
  end

`ifdef MAM_WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        slave_resp;
  logic        stalled;

  assign slave_resp  = wb_out_ack_o | wb_out_err_o | wb_out_rty_o;
  assign stalled     = (state != ST_IDLE) && pre_stb && !slave_resp;
  // to_cnt counts the stalled cycles before this one. It fires on the
  // TIMEOUT-th stalled cycle.
  assign timeout_hit = stalled && (to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge wb_in_clk_i or posedge wb_in_rst_i) begin
    if (wb_in_rst_i) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == ST_IDLE || state_nxt != state || slave_resp) begin
        to_cnt <= '0;
      end else if (stalled) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (timeout_hit) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mam_wb_arbiter_nport.sv
// Directed testbench for mam_wb_arbiter_nport with two CPU masters, 32-bit
// address and data. Inputs change 1 time unit after the rising edge. Outputs
// are sampled on the falling edge.
module tb_mam_wb_arbiter_nport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] in_adr, in_dat_w;
  logic [7:0]  in_sel;
  logic [5:0]  in_cti;
  logic [3:0]  in_bte;
  logic [1:0]  in_cyc, in_stb, in_we;
  logic [1:0]  in_ack, in_err, in_rty;
  logic [63:0] in_dat_r;

  logic [31:0] mam_adr, mam_dat_w, mam_dat_r;
  logic [3:0]  mam_sel;
  logic [2:0]  mam_cti;
  logic [1:0]  mam_bte;
  logic        mam_cyc, mam_stb, mam_we, mam_ack, mam_err, mam_rty;

  logic [31:0] out_adr, out_dat_w, out_dat_r;
  logic [3:0]  out_sel;
  logic [2:0]  out_cti;
  logic [1:0]  out_bte;
  logic        out_cyc, out_stb, out_we, out_ack, out_err, out_rty;

  logic        grant_mam;
  logic [1:0]  grant;
  logic [1:0]  state;
`ifdef MAM_WB_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  mam_wb_arbiter_nport #(
    .AW(32), .DW(32), .NUM_MASTERS(2), .TIMEOUT(8)
  ) dut (
    .wb_in_clk_i (clk),
    .wb_in_rst_i (rst),
    .wb_in_adr_i (in_adr),
    .wb_in_dat_i (in_dat_w),
    .wb_in_sel_i (in_sel),
    .wb_in_cti_i (in_cti),
    .wb_in_bte_i (in_bte),
    .wb_in_cyc_i (in_cyc),
    .wb_in_stb_i (in_stb),
    .wb_in_we_i  (in_we),
    .wb_in_ack_o (in_ack),
    .wb_in_err_o (in_err),
    .wb_in_rty_o (in_rty),
    .wb_in_dat_o (in_dat_r),
    .wb_mam_adr_o(mam_adr),
    .wb_mam_dat_o(mam_dat_w),
    .wb_mam_sel_o(mam_sel),
    .wb_mam_cti_o(mam_cti),
    .wb_mam_bte_o(mam_bte),
    .wb_mam_cyc_o(mam_cyc),
    .wb_mam_stb_o(mam_stb),
    .wb_mam_we_o (mam_we),
    .wb_mam_ack_i(mam_ack),
    .wb_mam_err_i(mam_err),
    .wb_mam_rty_i(mam_rty),
    .wb_mam_dat_i(mam_dat_r),
    .wb_out_adr_i(out_adr),
    .wb_out_dat_i(out_dat_w),
    .wb_out_sel_i(out_sel),
    .wb_out_cti_i(out_cti),
    .wb_out_bte_i(out_bte),
    .wb_out_cyc_i(out_cyc),
    .wb_out_stb_i(out_stb),
    .wb_out_we_i (out_we),
    .wb_out_ack_o(out_ack),
    .wb_out_err_o(out_err),
    .wb_out_rty_o(out_rty),
    .wb_out_dat_o(out_dat_r),
    .grant_mam_o (grant_mam),
    .grant_o     (grant),
    .state_o     (state)
`ifdef MAM_WB_ARB_TIMEOUT_EN
    ,
    .timeout_o   (timeout)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    in_adr = '0; in_dat_w = '0; in_sel = '1; in_cti = '0; in_bte = '0;
    in_cyc = '0; in_stb = '0; in_we = '0;
    mam_adr = '0; mam_dat_w = '0; mam_sel = '1; mam_cti = '0; mam_bte = '0;
    mam_cyc = 1'b0; mam_stb = 1'b0; mam_we = 1'b0;
    out_ack = 1'b0; out_err = 1'b0; out_rty = 1'b0; out_dat_r = '0;
  endtask

  task automatic settle();
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic req_cpu(input int k, input logic [31:0] adr, input logic [2:0] cti);
    in_cyc[k] = 1'b1;
    in_stb[k] = 1'b1;
    in_adr[k*32 +: 32] = adr;
    in_cti[k*3 +: 3] = cti;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    out_ack = 1'b1;
    out_dat_r = 32'h1234_5678;
    mid();
    if (out_cyc !== 1'b0 || out_stb !== 1'b0) begin
      errors++; $display("FAIL reset_cyc_stb got=%b%b exp=00", out_cyc, out_stb);
    end
    checks++;
    if ({grant_mam, grant, state} !== 5'b0) begin
      errors++; $display("FAIL reset_grant got=%b exp=00000", {grant_mam, grant, state});
    end
    checks++;
    if (in_ack !== 2'b00 || in_dat_r !== 64'h0 || mam_ack !== 1'b0) begin
      errors++; $display("FAIL reset_resp got ack=%b dat=%h mam=%b exp 0", in_ack, in_dat_r, mam_ack);
    end
    checks++;
`ifdef MAM_WB_ARB_TIMEOUT_EN
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got=%b exp=0", timeout);
    end
    checks++;
`endif
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    tick();
    req_cpu(1, 32'h100, 3'b000);
    mid();
    if (out_cyc !== 1'b0) begin
      errors++; $display("FAIL rd_latency got=%b exp=0", out_cyc);
    end
    checks++;
    tick(); mid();
    if (out_cyc !== 1'b1 || out_adr !== 32'h100 || grant !== 2'b10) begin
      errors++; $display("FAIL rd_grant got cyc=%b adr=%h grant=%b exp 1 100 10", out_cyc, out_adr, grant);
    end
    checks++;
    tick(); mid();
    if (in_ack !== 2'b00) begin
      errors++; $display("FAIL rd_wait_ack got=%b exp=00", in_ack);
    end
    checks++;
    tick();
    out_ack = 1'b1; out_dat_r = 32'hDEAD_BEEF;
    mid();
    if (in_ack !== 2'b10) begin
      errors++; $display("FAIL rd_ack got=%b exp=10", in_ack);
    end
    checks++;
    if (in_dat_r !== 64'hDEAD_BEEF_0000_0000) begin
      errors++; $display("FAIL rd_data got=%h exp=deadbeef00000000", in_dat_r);
    end
    checks++;
    tick();
    out_ack = 1'b0; out_dat_r = '0;
    in_cyc[1] = 1'b0; in_stb[1] = 1'b0;
    tick(); mid();
    if (state !== 2'd0 || grant !== 2'b00) begin
      errors++; $display("FAIL rd_release got state=%0d grant=%b exp 0 00", state, grant);
    end
    checks++;
    settle();
  endtask

  task automatic test_mam_priority();
    tick();
    mam_cyc = 1'b1; mam_stb = 1'b1; mam_adr = 32'h300;
    req_cpu(0, 32'h40, 3'b000);
    tick(); mid();
    if (grant_mam !== 1'b1 || grant !== 2'b00 || out_adr !== 32'h300) begin
      errors++; $display("FAIL mam_first got mam=%b grant=%b adr=%h exp 1 00 300", grant_mam, grant, out_adr);
    end
    checks++;
    tick();
    out_ack = 1'b1;
    mid();
    if (mam_ack !== 1'b1 || in_ack !== 2'b00) begin
      errors++; $display("FAIL mam_ack got mam=%b cpu=%b exp 1 00", mam_ack, in_ack);
    end
    checks++;
    tick();
    out_ack = 1'b0; mam_cyc = 1'b0; mam_stb = 1'b0;
    tick(); mid();
    if (grant_mam !== 1'b0 || grant !== 2'b00 || out_cyc !== 1'b0) begin
      errors++; $display("FAIL mam_gap got mam=%b grant=%b cyc=%b exp 0 00 0", grant_mam, grant, out_cyc);
    end
    checks++;
    tick(); mid();
    if (grant !== 2'b01 || out_adr !== 32'h40) begin
      errors++; $display("FAIL mam_then_cpu got grant=%b adr=%h exp 01 40", grant, out_adr);
    end
    checks++;
    settle();
  endtask

  task automatic test_round_robin();
    // Master 0 won last, so master 1 is next.
    tick();
    req_cpu(0, 32'h10, 3'b000);
    req_cpu(1, 32'h20, 3'b000);
    for (int r = 0; r < 4; r++) begin
      int  exp_m;
      bit  seen;
      exp_m = (r % 2 == 0) ? 1 : 0;
      seen = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        mid();
        if (out_stb === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        errors++; $display("FAIL rr_timeout round=%0d got no stb exp stb", r);
      end
      checks++;
      if (grant !== 2'(1 << exp_m)) begin
        errors++; $display("FAIL rr_grant round=%0d got=%b exp=%b", r, grant, 2'(1 << exp_m));
      end
      checks++;
      tick();
      out_ack = 1'b1;
      mid();
      if (in_ack !== 2'(1 << exp_m)) begin
        errors++; $display("FAIL rr_ack round=%0d got=%b exp=%b", r, in_ack, 2'(1 << exp_m));
      end
      checks++;
      tick();
      out_ack = 1'b0;
      in_cyc[exp_m] = 1'b0; in_stb[exp_m] = 1'b0;
      tick();
      in_cyc[exp_m] = 1'b1; in_stb[exp_m] = 1'b1;
    end
    settle();
  endtask

  task automatic test_burst_no_preempt();
    bit seen;
    tick();
    req_cpu(0, 32'h200, 3'b010);
    tick(); mid();
    if (grant !== 2'b01) begin
      errors++; $display("FAIL burst_grant got=%b exp=01", grant);
    end
    checks++;
    for (int b = 0; b < 4; b++) begin
      tick();
      in_adr[31:0] = 32'h200 + 32'(4 * b);
      in_cti[2:0] = (b == 3) ? 3'b111 : 3'b010;
      out_ack = 1'b1;
      out_dat_r = 32'hA0 + 32'(b);
      if (b == 1) begin
        mam_cyc = 1'b1; mam_stb = 1'b1; mam_adr = 32'h300;
      end
      mid();
      if (out_adr !== 32'h200 + 32'(4 * b) || out_cti !== ((b == 3) ? 3'b111 : 3'b010)) begin
        errors++; $display("FAIL burst_fwd beat=%0d got adr=%h cti=%b", b, out_adr, out_cti);
      end
      checks++;
      if (in_ack !== 2'b01 || in_dat_r[31:0] !== 32'hA0 + 32'(b) || grant_mam !== 1'b0) begin
        errors++; $display("FAIL burst_ack beat=%0d got ack=%b dat=%h mam=%b exp 01 %h 0", b, in_ack, in_dat_r[31:0], grant_mam, 32'hA0 + 32'(b));
      end
      checks++;
    end
    tick();
    out_ack = 1'b0; out_dat_r = '0;
    in_cyc[0] = 1'b0; in_stb[0] = 1'b0;
    mid();
    if (grant_mam !== 1'b0) begin
      errors++; $display("FAIL burst_tail got mam=%b exp=0", grant_mam);
    end
    checks++;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      tick(); mid();
      if (grant_mam === 1'b1) seen = 1'b1;
    end
    if (!seen || out_adr !== 32'h300) begin
      errors++; $display("FAIL burst_mam_after got mam=%b adr=%h exp 1 300", grant_mam, out_adr);
    end
    checks++;
    settle();
  endtask

  task automatic test_async_reset();
    // Master 0 owns the port before the reset, so without the reset the next
    // round-robin winner would be master 1.
    tick();
    req_cpu(0, 32'h400, 3'b010);
    tick(); mid();
    if (grant !== 2'b01) begin
      errors++; $display("FAIL areset_pre got=%b exp=01", grant);
    end
    checks++;
    tick(); out_ack = 1'b1;
    tick(); in_adr[31:0] = 32'h404;
    mid();
    #1 rst = 1'b1;
    #1;
    if (out_cyc !== 1'b0 || out_stb !== 1'b0 || grant !== 2'b00 || in_ack !== 2'b00) begin
      errors++; $display("FAIL areset_immediate got cyc=%b stb=%b grant=%b ack=%b exp 0 0 00 00", out_cyc, out_stb, grant, in_ack);
    end
    checks++;
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    req_cpu(0, 32'h10, 3'b000);
    req_cpu(1, 32'h20, 3'b000);
    tick(); mid();
    if (grant !== 2'b01) begin
      errors++; $display("FAIL areset_priority got=%b exp=01", grant);
    end
    checks++;
    settle();
  endtask

`ifdef MAM_WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    req_cpu(0, 32'h500, 3'b000);
    tick();
    for (int c = 0; c < 7; c++) begin
      mid();
      if ({in_err, out_cyc} !== 3'b001) begin
        errors++; $display("FAIL to_stall cycle=%0d got err=%b cyc=%b exp 00 1", c, in_err, out_cyc);
      end
      checks++;
      tick();
    end
    mid();
    if (in_err !== 2'b01 || out_cyc !== 1'b0 || out_stb !== 1'b0) begin
      errors++; $display("FAIL to_fire got err=%b cyc=%b stb=%b exp 01 0 0", in_err, out_cyc, out_stb);
    end
    checks++;
    tick();
    in_cyc[0] = 1'b0; in_stb[0] = 1'b0;
    mid();
    if (timeout !== 1'b1 || state !== 2'd0 || in_err !== 2'b00) begin
      errors++; $display("FAIL to_after got timeout=%b state=%0d err=%b exp 1 0 00", timeout, state, in_err);
    end
    checks++;
    settle();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_mam_priority();
    test_round_robin();
    test_burst_no_preempt();
    test_async_reset();
`ifdef MAM_WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
